// File: rtl/loader_pkg.sv
// Shared definitions for the framed serial bank loader.
// Optional feature macro: UART_LOADER_CSUM_EN adds the trailing checksum
// byte and the CSUM state.
package loader_pkg;

    // Frame parser states, in the order the header fields arrive.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN0 = 3'd2,
        ST_LEN1 = 3'd3,
        ST_ADR0 = 3'd4,
        ST_ADR1 = 3'd5,
        ST_DATA = 3'd6
`ifdef UART_LOADER_CSUM_EN
        ,
        ST_CSUM = 3'd7
`endif
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    // Byte offsets of the header fields, counted from the SYNC byte.
    localparam int HDR_OFS_CMD = 1;
    localparam int HDR_OFS_LEN = 2;
    localparam int HDR_OFS_ADR = 4;
    localparam int HDR_LEN     = 6;

    localparam int LEN_W = 16;

    // A length is usable when it is non-zero and fits inside one bank.
    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int addr_w);
        return (len != '0) && ({16'b0, len} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/rx_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse for a slow strobe
// coming from another clock domain. The pulse is one clock wide and appears
// three clocks after the input rises.
module rx_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_pulse;

    // Synchronise the strobe, keep one cycle of history, register the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_pulse  <= r_sync & ~r_sync_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/uart_bank_loader.sv
// Framed serial program loader. Parses SYNC / bank / length / address
// headers from the serial receiver and writes the payload into one of
// 2**BANK_W memory banks while holding the CPU in reset via prg_busy.
// Optional feature macro: UART_LOADER_CSUM_EN (trailing checksum byte).
module uart_bank_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W  = 14,
    parameter int         BANK_W  = 2,
    parameter int         TIMEOUT = 5_000_000,
    parameter logic [7:0] SYNC    = DEFAULT_SYNC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_ready,
    output logic [ADDR_W-1:0]        prg_addr,
    output logic [7:0]               prg_data,
    output logic [(1<<BANK_W)-1:0]   prg_wren,
    output logic                     prg_busy,
    output logic                     prg_done,
    output logic                     prg_error
);

    localparam int NBANK = 1 << BANK_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT - 1);

    logic              w_evt;
    logic              w_expire;
    logic [NBANK-1:0]  w_wren_hot;

    state_t            r_state;
    logic [BANK_W-1:0] r_bank;
    logic [LEN_W-1:0]  r_len;
    logic [7:0]        r_adr_lo;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_sum;
    logic [TMO_W-1:0]  r_tmo;
`ifndef UART_LOADER_CSUM_EN
    logic              r_fin;
`endif

    rx_edge_sync u_rx_sync (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_async (rx_ready),
        .o_pulse (w_evt)
    );

    assign w_wren_hot = NBANK'(1) << r_bank;

    // A byte arriving in the expiry cycle takes priority over the abort.
    assign w_expire = (r_state != ST_IDLE) && (r_tmo == '0) && !w_evt;

    // Idle timer: reloads on every byte and whenever no frame is open.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo <= TMO_RELOAD;
        end else if (w_evt || (r_state == ST_IDLE)) begin
            r_tmo <= TMO_RELOAD;
        end else if (r_tmo != '0) begin
            r_tmo <= r_tmo - TMO_W'(1);
        end
    end

    // Frame parser with registered write port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bank    <= '0;
            r_len     <= '0;
            r_adr_lo  <= '0;
            r_addr    <= '0;
            r_sum     <= '0;
            prg_addr  <= '0;
            prg_data  <= '0;
            prg_wren  <= '0;
            prg_busy  <= 1'b0;
            prg_done  <= 1'b0;
            prg_error <= 1'b0;
`ifndef UART_LOADER_CSUM_EN
            r_fin     <= 1'b0;
`endif
        end else begin
            prg_wren <= '0;
            prg_done <= 1'b0;
`ifndef UART_LOADER_CSUM_EN
            // Without a checksum the frame completes one cycle after the last write.
            if (r_fin) begin
                prg_done <= 1'b1;
                prg_busy <= 1'b0;
                r_fin    <= 1'b0;
            end
`endif
            if (w_evt) begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_byte == SYNC) begin
                            r_state   <= ST_CMD;
                            prg_busy  <= 1'b1;
                            prg_error <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        r_bank  <= rx_byte[BANK_W-1:0];
                        r_state <= ST_LEN0;
                    end
                    ST_LEN0: begin
                        r_len[7:0] <= rx_byte;
                        r_state    <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        if (len_ok({rx_byte, r_len[7:0]}, ADDR_W)) begin
                            r_len[15:8] <= rx_byte;
                            r_state     <= ST_ADR0;
                        end else begin
                            r_state   <= ST_IDLE;
                            prg_busy  <= 1'b0;
                            prg_error <= 1'b1;
                        end
                    end
                    ST_ADR0: begin
                        r_adr_lo <= rx_byte;
                        r_state  <= ST_ADR1;
                    end
                    ST_ADR1: begin
                        r_addr  <= ADDR_W'({rx_byte, r_adr_lo});
                        r_sum   <= '0;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        prg_addr <= r_addr;
                        prg_data <= rx_byte;
                        prg_wren <= w_wren_hot;
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_len    <= r_len - LEN_W'(1);
                        r_sum    <= r_sum + rx_byte;
                        if (r_len == LEN_W'(1)) begin
`ifdef UART_LOADER_CSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_IDLE;
                            r_fin   <= 1'b1;
`endif
                        end
                    end
`ifdef UART_LOADER_CSUM_EN
                    ST_CSUM: begin
                        if (rx_byte == r_sum) begin
                            prg_done <= 1'b1;
                        end else begin
                            prg_error <= 1'b1;
                        end
                        prg_busy <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (w_expire) begin
                r_state   <= ST_IDLE;
                prg_busy  <= 1'b0;
                prg_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_bank_loader.sv
// Self-checking bench for uart_bank_loader: reference frame parser built on
// byte queues, table-driven frames, random frames and hand-written corner
// sequences (exact example frame, timeout, reset during payload).
module tb_uart_bank_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 14;
  localparam int BANK_W = 2;
  localparam int TIMEOUT = 200;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int NBANK = 1 << BANK_W;
  localparam int BANK_SIZE = 1 << ADDR_W;
  localparam int WR_W = NBANK + ADDR_W + 8;
`ifdef UART_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic [7:0] rx_byte;
  logic rx_ready;
  logic [ADDR_W-1:0] prg_addr;
  logic [7:0] prg_data;
  logic [NBANK-1:0] prg_wren;
  logic prg_busy;
  logic prg_done;
  logic prg_error;

  uart_bank_loader #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .TIMEOUT(TIMEOUT), .SYNC(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .prg_addr(prg_addr), .prg_data(prg_data), .prg_wren(prg_wren),
    .prg_busy(prg_busy), .prg_done(prg_done), .prg_error(prg_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [WR_W-1:0] exp_q[$];
  logic [WR_W-1:0] obs_q[$];
  logic [7:0] tx_q[$];
  int done_cnt;
  bit m_done;
  bit m_err;
  int total;
  int bad;

  typedef struct {
    int junk; int bank; int len; int addr; int n_send; bit good;
    int exp_nw; bit exp_done; bit exp_err;
  } vec_t;
  vec_t vecs[8];

  // write monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (prg_wren != '0) obs_q.push_back({prg_wren, prg_addr, prg_data});
    if (prg_done) done_cnt++;
  end

  function automatic logic [WR_W-1:0] mk_wr(int bank, int addr, int data);
    logic [NBANK-1:0] hot;
    hot = '0;
    hot[bank] = 1'b1;
    return {hot, ADDR_W'(addr), 8'(data)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference parser: walks the transmitted byte list the way the frame
  // format is defined and lists the writes and the outcome it implies.
  task automatic model_parse();
    int i, bank, len, start, p, n, sum;
    exp_q.delete();
    m_done = 1'b0;
    m_err = 1'b0;
    i = 0;
    while (i < tx_q.size() && tx_q[i] != SYNC) i++;
    if (i + HDR_OFS_LEN + 1 >= tx_q.size()) begin
      m_err = (i < tx_q.size());
      return;
    end
    bank = int'(tx_q[i + HDR_OFS_CMD]) % NBANK;
    len = int'(tx_q[i + HDR_OFS_LEN]) + 256 * int'(tx_q[i + HDR_OFS_LEN + 1]);
    if (len == 0 || len > BANK_SIZE) begin
      m_err = 1'b1;
      return;
    end
    start = (int'(tx_q[i + HDR_OFS_ADR]) + 256 * int'(tx_q[i + HDR_OFS_ADR + 1])) % BANK_SIZE;
    p = i + HDR_LEN;
    n = 0;
    sum = 0;
    while (n < len && p < tx_q.size()) begin
      exp_q.push_back(mk_wr(bank, (start + n) % BANK_SIZE, tx_q[p]));
      sum = (sum + int'(tx_q[p])) % 256;
      n++;
      p++;
    end
    if (n < len) begin
      m_err = 1'b1;
      return;
    end
    if (CSUM_ON) begin
      if (p < tx_q.size() && int'(tx_q[p]) == sum) m_done = 1'b1;
      else m_err = 1'b1;
    end else begin
      m_done = 1'b1;
    end
  endtask

  // driver
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #2;
    rx_byte = b;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rx_ready = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_all();
    foreach (tx_q[k]) send_byte(tx_q[k]);
  endtask

  task automatic build_frame(input int junk, input int bank, input int len, input int addr,
                             input int n_send, input bit good);
    logic [7:0] b;
    logic [15:0] a16;
    logic [15:0] l16;
    int sum;
    tx_q.delete();
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      tx_q.push_back(b);
    end
    tx_q.push_back(SYNC);
    tx_q.push_back({6'($urandom_range(0, 63)), 2'(bank)});
    l16 = 16'(len);
    tx_q.push_back(l16[7:0]);
    tx_q.push_back(l16[15:8]);
    if (len == 0 || len > BANK_SIZE) return;
    a16 = {2'($urandom_range(0, 3)), 14'(addr)};
    tx_q.push_back(a16[7:0]);
    tx_q.push_back(a16[15:8]);
    sum = 0;
    for (int j = 0; j < n_send; j++) begin
      b = 8'($urandom_range(0, 255));
      tx_q.push_back(b);
      sum = (sum + int'(b)) % 256;
    end
    if (CSUM_ON && n_send == len) tx_q.push_back(good ? 8'(sum) : (8'(sum) ^ 8'h5A));
  endtask

  task automatic clear_sb();
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic check_frame(input string name, input int exp_nw, input bit exp_done,
                             input bit exp_err, input int wait_cyc);
    int n;
    repeat (wait_cyc) @(negedge clk);
    model_parse();
    check({name, " nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    check({name, " nwrites_tbl"}, 32'(obs_q.size()), 32'(exp_nw));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) check($sformatf("%s write%0d", name, k), 32'(obs_q[k]), 32'(exp_q[k]));
    check({name, " done"}, 32'(done_cnt), 32'(m_done));
    check({name, " done_tbl"}, 32'(done_cnt), 32'(exp_done));
    check({name, " error"}, 32'(prg_error), 32'(m_err));
    check({name, " error_tbl"}, 32'(prg_error), 32'(exp_err));
    check({name, " busy"}, 32'(prg_busy), 32'd0);
    clear_sb();
  endtask

  initial begin
    logic [7:0] plan_d[4];
    bit seen;
    int rl, rg;
    total = 0;
    bad = 0;
    done_cnt = 0;
    rx_byte = 8'h00;
    rx_ready = 1'b0;
    plan_d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    vecs[0] = '{0, 1, 4, 'h0010, 4, 1'b1, 4, 1'b1, 1'b0};
    vecs[1] = '{0, 1, 4, 'h0010, 4, 1'b0, 4, !CSUM_ON, CSUM_ON};
    vecs[2] = '{0, 2, 4, 'h3FFE, 4, 1'b1, 4, 1'b1, 1'b0};
    vecs[3] = '{3, 0, 3, 'h0100, 3, 1'b1, 3, 1'b1, 1'b0};
    vecs[4] = '{0, 3, 0, 'h0000, 0, 1'b1, 0, 1'b0, 1'b1};
    vecs[5] = '{0, 2, 'h4001, 'h0000, 0, 1'b1, 0, 1'b0, 1'b1};
    vecs[6] = '{0, 0, 1, 'h2222, 1, 1'b1, 1, 1'b1, 1'b0};
    vecs[7] = '{2, 3, 6, 'h1234, 6, 1'b1, 6, 1'b1, 1'b0};

    // reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst addr", 32'(prg_addr), 32'd0);
    check("rst data", 32'(prg_data), 32'd0);
    check("rst wren", 32'(prg_wren), 32'd0);
    check("rst busy", 32'(prg_busy), 32'd0);
    check("rst done", 32'(prg_done), 32'd0);
    check("rst error", 32'(prg_error), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    clear_sb();

    // exact example frame with hand-computed writes
    tx_q = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CSUM_ON) tx_q.push_back(8'h38);
    foreach (tx_q[k]) begin
      send_byte(tx_q[k]);
      if (k == 0) check("plan busy_after_sync", 32'(prg_busy), 32'd1);
    end
    repeat (20) @(negedge clk);
    check("plan nwrites", 32'(obs_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < obs_q.size(); k++)
      check($sformatf("plan write%0d", k), 32'(obs_q[k]), 32'(mk_wr(1, 'h10 + k, plan_d[k])));
    check("plan done", 32'(done_cnt), 32'd1);
    check("plan error", 32'(prg_error), 32'd0);
    check("plan busy", 32'(prg_busy), 32'd0);
    clear_sb();

`ifdef UART_LOADER_CSUM_EN
    tx_q = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    send_all();
    repeat (20) @(negedge clk);
    check("badcs nwrites", 32'(obs_q.size()), 32'd4);
    check("badcs done", 32'(done_cnt), 32'd0);
    check("badcs error", 32'(prg_error), 32'd1);
    check("badcs busy", 32'(prg_busy), 32'd0);
    clear_sb();
`endif

    // table-driven frames
    for (int v = 0; v < 8; v++) begin
      build_frame(vecs[v].junk, vecs[v].bank, vecs[v].len, vecs[v].addr, vecs[v].n_send, vecs[v].good);
      send_all();
      check_frame($sformatf("vec%0d", v), vecs[v].exp_nw, vecs[v].exp_done, vecs[v].exp_err, 30);
    end

    // random frames
    for (int r = 0; r < 6; r++) begin
      rl = $urandom_range(1, 8);
      rg = $urandom_range(0, 1);
      build_frame($urandom_range(0, 2), $urandom_range(0, NBANK - 1), rl,
                  $urandom_range(0, BANK_SIZE - 1), rl, rg[0]);
      send_all();
      check_frame($sformatf("rand%0d", r), rl, CSUM_ON ? rg[0] : 1'b1,
                  CSUM_ON ? !rg[0] : 1'b0, 30);
    end

    // timeout after two of four payload bytes, then SYNC clears the error
    build_frame(0, 2, 4, 'h0020, 2, 1'b1);
    send_all();
    repeat (2) @(negedge clk);
    check("tmo busy_before", 32'(prg_busy), 32'd1);
    check_frame("tmo", 2, 1'b0, 1'b1, TIMEOUT + 30);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h77};
    if (CSUM_ON) tx_q.push_back(8'h77);
    foreach (tx_q[k]) begin
      send_byte(tx_q[k]);
      if (k == 0) begin
        check("tmo err_cleared", 32'(prg_error), 32'd0);
        check("tmo busy_again", 32'(prg_busy), 32'd1);
      end
    end
    check_frame("tmo_next", 1, 1'b1, 1'b0, 20);

    // reset during payload
    build_frame(0, 1, 8, 'h0040, 8, 1'b1);
    for (int k = 0; k < 8; k++) send_byte(tx_q[k]);
    @(posedge clk);
    #2;
    rx_byte = tx_q[8];
    rx_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (prg_wren != '0) seen = 1'b1;
    end
    check("rstmid wren_seen", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rstmid wren", 32'(prg_wren), 32'd0);
    check("rstmid addr", 32'(prg_addr), 32'd0);
    check("rstmid data", 32'(prg_data), 32'd0);
    check("rstmid busy", 32'(prg_busy), 32'd0);
    check("rstmid done", 32'(prg_done), 32'd0);
    check("rstmid error", 32'(prg_error), 32'd0);
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    clear_sb();
    build_frame(0, 3, 5, 'h0300, 5, 1'b1);
    send_all();
    check_frame("after_rst", 5, 1'b1, 1'b0, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
